// File: rtl/gb_sequencer_if.sv
// Program-load and run-control bus between a host and gb_sequencer.
interface gb_sequencer_if #(parameter int AW = 4);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW:0]   prog_len;
    logic [3:0]    loops;
    logic          start;
    logic          abort;
    logic [7:0]    instruction;
    logic          valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    modport master (output wr_en, wr_addr, wr_data, prog_len, loops, start, abort,
                    input  instruction, valid, busy, done, pc);
    modport slave  (input  wr_en, wr_addr, wr_data, prog_len, loops, start, abort,
                    output instruction, valid, busy, done, pc);
endinterface

// File: rtl/gb_sequencer.sv
// Instruction sequencer: plays mem[0..len-1] once per pass, loops+1 passes per run.
//
// state | meaning
// IDLE  | waiting for start; program memory writable
// RUN   | presenting one instruction per cycle
// DONE  | one-cycle completion pulse; program memory writable
module gb_sequencer #(
    parameter int DEPTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    gb_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW:0]   len_q, len_d;
    logic [4:0]    pass_q, pass_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          accept;
    logic          last_instr;
    logic [AW:0]   len_clamped;
    logic [AW-1:0] pc_inc;

    always_comb begin
        accept      = (state_q == IDLE) && bus.start && !bus.abort && (bus.prog_len != '0);
        len_clamped = (bus.prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.prog_len;
        last_instr  = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
        pc_inc      = pc_q + AW'(1);

        state_d = state_q;
        mem_d   = mem_q;
        len_d   = len_q;
        pass_d  = pass_q;
        pc_d    = pc_q;
        instr_d = 8'h00;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        // An accepted start owns the cycle, so a coincident write is dropped.
        if (bus.wr_en && (state_q != RUN) && !accept)
            mem_d[bus.wr_addr] = bus.wr_data;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    len_d   = len_clamped;
                    pass_d  = 5'(bus.loops) + 5'd1;
                    pc_d    = '0;
                    instr_d = mem_q[0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (last_instr) begin
                    pass_d = pass_q - 5'd1;
                    if (pass_q == 5'd1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        pc_d    = '0;
                        instr_d = mem_q[0];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    pc_d    = pc_inc;
                    instr_d = mem_q[pc_inc];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mem_q   <= '{default: 8'h00};
            len_q   <= '0;
            pass_q  <= '0;
            pc_q    <= '0;
            instr_q <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            len_q   <= len_d;
            pass_q  <= pass_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.valid       = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pc          = pc_q;
endmodule

// File: tb/tb_gb_sequencer.sv
// Randomized bench for gb_sequencer against a run-level reference of the program memory.
module tb_gb_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic clock = 1'b0;
    logic reset = 1'b1;

    gb_sequencer_if #(.AW(AW)) bus ();

    gb_sequencer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mdl_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag, input int exp_pc);
        chk({tag, ".valid"}, 32'(bus.valid), 32'd0);
        chk({tag, ".busy"},  32'(bus.busy),  32'd0);
        chk({tag, ".done"},  32'(bus.done),  32'd0);
        chk({tag, ".instr"}, 32'(bus.instruction), 32'h00);
        chk({tag, ".pc"},    32'(bus.pc), 32'(exp_pc));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
        chk_quiet("reset", 0);
    endtask

    task automatic mem_wr(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[AW-1:0];
        bus.wr_data = d[7:0];
        @(negedge clock);
        bus.wr_en   = 1'b0;
        mdl_mem[a]  = d[7:0];
    endtask

    // One run: expected stream is mem[k % len] for k in 0..len*(loops+1)-1.
    task automatic do_run(input int plen, input int lps, input int kill_at,
                          input bit kill_rst, input bit abort_start);
        int len, total, idx, last_pc;
        bit accepted, collide;
        int ca, cd;
        accepted = (plen != 0) && !abort_start;
        len      = (plen > DEPTH) ? DEPTH : plen;
        total    = len * (lps + 1);
        last_pc  = int'(bus.pc);

        bus.prog_len = plen[AW:0];
        bus.loops    = lps[3:0];
        bus.start    = 1'b1;
        bus.abort    = abort_start;
        collide      = ($urandom_range(0, 1) == 1);
        ca           = $urandom_range(0, DEPTH - 1);
        cd           = $urandom_range(0, 255);
        if (collide) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = ca[AW-1:0];
            bus.wr_data = cd[7:0];
            if (!accepted) mdl_mem[ca] = cd[7:0];
        end
        @(negedge clock);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.wr_en = 1'b0;

        if (!accepted) begin
            chk_quiet("no_start", last_pc);
            @(negedge clock);
            chk_quiet("no_start2", last_pc);
            return;
        end

        for (int k = 0; k < total; k++) begin
            idx = k % len;
            chk("run.valid", 32'(bus.valid), 32'd1);
            chk("run.busy",  32'(bus.busy),  32'd1);
            chk("run.done",  32'(bus.done),  32'd0);
            chk("run.instr", 32'(bus.instruction), 32'(mdl_mem[idx]));
            chk("run.pc",    32'(bus.pc), 32'(idx));
            bus.wr_en   = ($urandom_range(0, 1) == 1);
            bus.wr_addr = AW'($urandom_range(0, DEPTH - 1));
            bus.wr_data = 8'($urandom_range(0, 255));
            if (k == kill_at) begin
                if (kill_rst) reset = 1'b1;
                else          bus.abort = 1'b1;
                @(negedge clock);
                reset     = 1'b0;
                bus.abort = 1'b0;
                bus.wr_en = 1'b0;
                if (kill_rst) begin
                    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
                    chk_quiet("midrun_reset", 0);
                end else begin
                    chk_quiet("abort", idx);
                end
                return;
            end
            @(negedge clock);
        end

        chk("end.valid", 32'(bus.valid), 32'd0);
        chk("end.busy",  32'(bus.busy),  32'd0);
        chk("end.done",  32'(bus.done),  32'd1);
        chk("end.instr", 32'(bus.instruction), 32'h00);
        chk("end.pc",    32'(bus.pc), 32'(len - 1));
        // Start is ignored in the completion cycle, but writes land.
        bus.start   = 1'b1;
        bus.wr_en   = ($urandom_range(0, 1) == 1);
        ca          = $urandom_range(0, DEPTH - 1);
        cd          = $urandom_range(0, 255);
        bus.wr_addr = ca[AW-1:0];
        bus.wr_data = cd[7:0];
        if (bus.wr_en) mdl_mem[ca] = cd[7:0];
        @(negedge clock);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk_quiet("after_done", len - 1);
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = 8'h00;
        bus.prog_len = '0;
        bus.loops    = 4'd0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;

        do_reset();
        mem_wr(0, 8'h80);
        mem_wr(1, 8'h88);
        mem_wr(2, 8'h90);
        do_run(3, 0, -1, 1'b0, 1'b0);
        do_run(3, 2, -1, 1'b0, 1'b0);
        do_run(0, 0, -1, 1'b0, 1'b0);
        do_run(3, 1, -1, 1'b0, 1'b1);
        do_run(3, 0, -1, 1'b0, 1'b0);
        chk("prog_intact", 32'(mdl_mem[1]), 32'h88);

        for (int i = 3; i < DEPTH; i++) mem_wr(i, $urandom_range(0, 255));
        do_run(16, 0, 1, 1'b0, 1'b0);
        do_run(16, 0, -1, 1'b0, 1'b0);
        do_run(31, 1, -1, 1'b0, 1'b0);
        do_run(31, 15, -1, 1'b0, 1'b0);
        do_run(31, 0, 5, 1'b1, 1'b0);
        do_run(16, 0, -1, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            int nw, plen, lps, kill;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++)
                mem_wr($urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
            plen = $urandom_range(0, 20);
            lps  = $urandom_range(0, 15);
            kill = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
            do_run(plen, lps, kill, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gb_sequencer.md
GB_SEQUENCER -- requirements
Module: gb_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, program memory depth in instructions; power of two, 2..256; AW = log2(DEPTH).
REQ-002 clock  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 wr_en  in  1  program memory write strobe.
REQ-005 wr_addr  in  AW  program memory write address.
REQ-006 wr_data  in  8  instruction byte to store.
REQ-007 prog_len  in  AW+1  number of instructions per pass; sampled only when start is accepted.
REQ-008 loops  in  4  extra passes; total passes = loops+1; sampled only when start is accepted.
REQ-009 start  in  1  run request, level-sampled.
REQ-010 abort  in  1  terminate the current run.
REQ-011 instruction  out  8  instruction byte to the processor.
REQ-012 valid  out  1  instruction is valid this cycle.
REQ-013 busy  out  1  high while in RUN.
REQ-014 done  out  1  one-cycle pulse on normal run completion.
REQ-015 pc  out  AW  memory index of the instruction currently presented.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-017 In IDLE or DONE, wr_en=1 SHALL write wr_data to mem[wr_addr] at the clock edge; in RUN, writes SHALL be dropped.
REQ-018 Start acceptance: in IDLE, start=1, abort=0 and prog_len!=0 SHALL latch len=min(prog_len,DEPTH) and passes=loops+1, then enter RUN.
REQ-019 start SHALL be ignored when prog_len=0, in RUN, or in DONE.
REQ-020 If wr_en and an accepted start occur in the same cycle, the write SHALL be dropped.
REQ-021 Latency: the cycle after start is accepted, outputs SHALL show valid=1, instruction=mem[0], pc=0.
REQ-022 RUN SHALL present one instruction per cycle with no bubbles: mem[0..len-1] in order.
REQ-023 After mem[len-1], pc SHALL wrap to 0 and the pass counter SHALL decrement while passes remain.
REQ-024 The cycle after the last instruction of the last pass: valid=0, busy=0, done=1, state=DONE.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-026 Total valid cycles per run SHALL be exactly len*(loops+1), at most DEPTH*16.
REQ-027 When valid=0, instruction SHALL be 8'h00 and pc SHALL hold its last value; pc=0 after reset.
REQ-028 abort=1 in RUN SHALL give, on the next cycle, valid=0, busy=0, done=0, state=IDLE.
REQ-029 abort=1 in IDLE or DONE SHALL suppress any start that cycle; DONE still proceeds to IDLE.
REQ-030 busy SHALL equal 1 exactly in the cycles where valid=1.

Reset
REQ-031 reset SHALL dominate all inputs.
REQ-032 On reset the block SHALL enter state IDLE with valid=0, busy=0, done=0, instruction=8'h00, pc=0.
REQ-033 On reset all memory entries SHALL be cleared to 8'h00 and the length and pass counters to 0.
REQ-034 reset asserted mid-RUN SHALL drop valid on the cycle after the reset edge, with no done pulse.

Verification
REQ-035 Reset, then write mem[0..2]=8'h80,8'h88,8'h90; start with prog_len=3, loops=0 -> valid for 3 cycles carrying 80,88,90 with pc=0,1,2; next cycle done=1.
REQ-036 Same program with loops=2 -> 9 consecutive valid cycles carrying 80,88,90 three times; single done pulse after cycle 9.
REQ-037 prog_len=0, start=1 -> valid, busy and done stay 0; state stays IDLE.
REQ-038 During a run, wr_en=1 with wr_addr=1, wr_data=8'hFF -> ignored; a rerun still yields 8'h88 at pc=1.
REQ-039 abort asserted on the 2nd valid cycle of a 16-entry run -> valid=0 the next cycle, no done; a subsequent start restarts at pc=0.
REQ-040 prog_len=DEPTH+? clamp check (prog_len=31, DEPTH=16) -> exactly 16 valid cycles per pass; reset asserted mid-run -> outputs match the reset values one cycle later.
